// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IFU)
// and load/store (LSU), with a single outstanding transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_gnt,
    output logic                  ifu_rvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state_reg, state_next;
    logic   owner_reg;
    logic   last_reg;
    logic   latch;
    logic   win_lsu;

    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [STRB_W-1:0] mem_wstrb_reg;

    // On a tie the requester that did not win last time takes the port.
    always_comb begin
        state_next = state_reg;
        latch      = 1'b0;
        win_lsu    = lsu_req & (~ifu_req | ~last_reg);
        case (state_reg)
            IDLE: begin
                if (ifu_req | lsu_req) begin
                    latch      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request fields are captured once in IDLE and held stable through REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg     <= 1'b0;
            last_reg      <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
        end else if (latch) begin
            owner_reg     <= win_lsu;
            last_reg      <= win_lsu;
            mem_we_reg    <= win_lsu & lsu_we;
            mem_addr_reg  <= win_lsu ? lsu_addr : ifu_addr;
            mem_wdata_reg <= win_lsu ? lsu_wdata : '0;
            mem_wstrb_reg <= win_lsu ? lsu_wstrb : '0;
        end
    end

    assign mem_req   = (state_reg == REQ);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign busy      = (state_reg != IDLE);

    // Index 0 is the IFU side, index 1 the LSU side; only the owner sees traffic.
    logic [1:0]        gnt_vec;
    logic [1:0]        rvalid_vec;
    logic [DATA_W-1:0] rdata_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_route
        assign gnt_vec[gi]    = mem_gnt & (state_reg == REQ) & (owner_reg == 1'(gi));
        assign rvalid_vec[gi] = mem_rvalid & (state_reg == RESP) & (owner_reg == 1'(gi));
        assign rdata_arr[gi]  = rvalid_vec[gi] ? mem_rdata : '0;
    end

    assign ifu_gnt    = gnt_vec[0];
    assign lsu_gnt    = gnt_vec[1];
    assign ifu_rvalid = rvalid_vec[0];
    assign lsu_rvalid = rvalid_vec[1];
    assign ifu_rdata  = rdata_arr[0];
    assign lsu_rdata  = rdata_arr[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder, response monitor and an expected-response
// queue checked in order against what the DUT delivers to each requester.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_gnt, ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    // Memory side is either the automatic responder or driven by hand.
    logic        auto_mem = 1'b0;
    int          gnt_delay = 0;
    int          resp_delay = 0;
    logic        r_gnt = 1'b0, r_rvalid = 1'b0;
    logic [31:0] r_rdata = '0;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    assign mem_gnt    = auto_mem ? r_gnt    : m_gnt;
    assign mem_rvalid = auto_mem ? r_rvalid : m_rvalid;
    assign mem_rdata  = auto_mem ? r_rdata  : m_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_5A5A);
    endfunction

    bit          granted = 1'b0;
    int          wcnt = 0;
    logic [31:0] cap_addr = '0;

    always @(posedge clk) begin
        #1;
        if (!auto_mem) begin
            granted = 1'b0; wcnt = 0; r_gnt = 1'b0; r_rvalid = 1'b0; r_rdata = '0;
        end else if (mem_req && !granted) begin
            r_rvalid = 1'b0; r_rdata = '0;
            if (wcnt == gnt_delay) begin
                r_gnt = 1'b1; granted = 1'b1; wcnt = 0; cap_addr = mem_addr;
            end else begin
                r_gnt = 1'b0; wcnt++;
            end
        end else if (granted) begin
            r_gnt = 1'b0;
            if (wcnt == resp_delay) begin
                r_rvalid = 1'b1; r_rdata = model(cap_addr); granted = 1'b0; wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            r_gnt = 1'b0; r_rvalid = 1'b0; r_rdata = '0;
        end
    end

    // Owner code 2 marks both rvalids high in the same cycle.
    int          obs_cnt = 0;
    logic [1:0]  obs_owner [256];
    logic [31:0] obs_data  [256];

    always @(negedge clk) begin
        if (ifu_rvalid || lsu_rvalid) begin
            if (obs_cnt < 256) begin
                obs_owner[obs_cnt[7:0]] = (ifu_rvalid && lsu_rvalid) ? 2'd2 : {1'b0, lsu_rvalid};
                obs_data[obs_cnt[7:0]]  = lsu_rvalid ? lsu_rdata : ifu_rdata;
            end
            obs_cnt++;
        end
    end

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   rd_idx = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic wait_obs(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (obs_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ifu_gnt, lsu_gnt,
             ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs req=%b addr=%h wdata=%h rv=%b%b rd=%h/%h busy=%b, need all zero",
                     mem_req, mem_addr, mem_wdata, ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata, busy);
        end
        @(posedge clk); #1;
        m_rvalid = 1'b0; m_rdata = '0;
        rst = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_single_ifu();
        exp_t e;
        bit   ok;
        auto_mem = 1'b1; gnt_delay = 0; resp_delay = 0;
        @(posedge clk); #1;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
        exp_q.push_back('{owner: 2'd0, data: 32'h0000_0413});
        @(negedge clk);
        n_tests++;
        if ({busy, ifu_gnt, mem_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL ifu_cycle_t busy/gnt/req=%b need 000", {busy, ifu_gnt, mem_req});
        end
        @(negedge clk);
        n_tests++;
        if ({ifu_gnt, lsu_gnt, busy, mem_req, mem_we, mem_wstrb, mem_addr} !== {4'b1011, 1'b0, 4'h0, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL ifu_grant gnt=%b%b busy=%b req=%b we=%b strb=%h addr=%h need 1/0/1/1/0/0/80000000",
                     ifu_gnt, lsu_gnt, busy, mem_req, mem_we, mem_wstrb, mem_addr);
        end
        @(posedge clk); #1;
        ifu_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ifu_rvalid, lsu_rvalid, busy, ifu_rdata} !== {3'b101, 32'h0000_0413}) begin
            n_fail++;
            $display("FAIL ifu_resp rvalid=%b%b busy=%b rdata=%h need 1/0/1/00000413",
                     ifu_rvalid, lsu_rvalid, busy, ifu_rdata);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ifu_idle_t3 busy=%b need 0", busy);
        end
        wait_obs(rd_idx + exp_q.size(), ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL ifu_sb_timeout got %0d responses need %0d", obs_cnt - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_cnt && rd_idx < 256) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_owner[rd_idx[7:0]] !== e.owner || obs_data[rd_idx[7:0]] !== e.data) begin
                n_fail++;
                $display("FAIL ifu_sb owner=%0d data=%h need owner=%0d data=%h", obs_owner[rd_idx[7:0]], obs_data[rd_idx[7:0]], e.owner, e.data);
            end
            rd_idx++;
        end
        exp_q.delete();
        $display("[TB] single ifu fetch done");
    endtask

    task automatic test_store_stall();
        exp_t e;
        bit   ok;
        int   gnt_cnt = 0;
        gnt_delay = 3; resp_delay = 0;
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        exp_q.push_back('{owner: 2'd1, data: model(32'h8000_1000)});
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {2'b11, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF}
                || lsu_gnt !== (i == 3) || ifu_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL store_stall_%0d req=%b we=%b addr=%h wdata=%h strb=%h gnt=%b%b need 1/1/80001000/deadbeef/f lsu_gnt=%b",
                         i, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ifu_gnt, lsu_gnt, (i == 3));
            end
            if (lsu_gnt) gnt_cnt++;
            if (i == 1) begin
                lsu_addr = 32'h1234_5678; lsu_wdata = 32'h0; lsu_wstrb = 4'h1;
            end
            @(posedge clk);
        end
        #1;
        lsu_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({lsu_rvalid, ifu_rvalid, mem_req, gnt_cnt[3:0]} !== {3'b100, 4'd1} || lsu_rdata !== model(32'h8000_1000)) begin
            n_fail++;
            $display("FAIL store_ack rvalid=%b%b req=%b gnts=%0d rdata=%h need lsu=1 ifu=0 req=0 gnts=1 rdata=%h",
                     lsu_rvalid, ifu_rvalid, mem_req, gnt_cnt, lsu_rdata, model(32'h8000_1000));
        end
        wait_obs(rd_idx + exp_q.size(), ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL store_sb_timeout got %0d responses need %0d", obs_cnt - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_cnt && rd_idx < 256) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_owner[rd_idx[7:0]] !== e.owner || obs_data[rd_idx[7:0]] !== e.data) begin
                n_fail++;
                $display("FAIL store_sb owner=%0d data=%h need owner=%0d data=%h", obs_owner[rd_idx[7:0]], obs_data[rd_idx[7:0]], e.owner, e.data);
            end
            rd_idx++;
        end
        exp_q.delete();
        $display("[TB] lsu store with stalls done");
    endtask

    task automatic test_tie();
        exp_t e;
        bit   ok;
        int   ng = 0;
        int   cyc = 0;
        int   last_cyc = 0;
        gnt_delay = 0; resp_delay = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_2000; lsu_wdata = '0; lsu_wstrb = '0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{owner: 2'(i % 2), data: (i % 2 == 0) ? model(32'h8000_0100) : model(32'h8000_2000)});
        end
        while (ng < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ifu_gnt || lsu_gnt) begin
                n_tests++;
                if ((ifu_gnt && lsu_gnt) || lsu_gnt !== 1'(ng % 2) || (ng > 0 && cyc - last_cyc != 3)) begin
                    n_fail++;
                    $display("FAIL tie_grant_%0d gnt=%b%b gap=%0d need lsu_gnt=%0d gap=3",
                             ng, ifu_gnt, lsu_gnt, cyc - last_cyc, ng % 2);
                end
                last_cyc = cyc;
                ng++;
            end
        end
        n_tests++;
        if (ng != 4) begin
            n_fail++;
            $display("FAIL tie_grant_count got %0d need 4", ng);
        end
        @(posedge clk); #1;
        ifu_req = 1'b0; lsu_req = 1'b0;
        wait_obs(rd_idx + exp_q.size(), ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL tie_sb_timeout got %0d responses need %0d", obs_cnt - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_cnt && rd_idx < 256) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_owner[rd_idx[7:0]] !== e.owner || obs_data[rd_idx[7:0]] !== e.data) begin
                n_fail++;
                $display("FAIL tie_sb owner=%0d data=%h need owner=%0d data=%h", obs_owner[rd_idx[7:0]], obs_data[rd_idx[7:0]], e.owner, e.data);
            end
            rd_idx++;
        end
        exp_q.delete();
        $display("[TB] tie round robin done, %0d grants", ng);
    endtask

    task automatic test_stray();
        exp_t e;
        bit   ok;
        repeat (3) @(posedge clk);
        #1;
        auto_mem = 1'b0; m_gnt = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hBAD0_0001;
        @(negedge clk);
        n_tests++;
        if ({ifu_rvalid, lsu_rvalid, busy, ifu_rdata, lsu_rdata} !== '0) begin
            n_fail++;
            $display("FAIL stray_idle rvalid=%b%b busy=%b rdata=%h/%h need all zero", ifu_rvalid, lsu_rvalid, busy, ifu_rdata, lsu_rdata);
        end
        @(posedge clk); #1;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0200;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, mem_req, ifu_gnt, ifu_rvalid, lsu_rvalid} !== 5'b11000) begin
            n_fail++;
            $display("FAIL stray_req busy/req/gnt/rvalid=%b need 11000", {busy, mem_req, ifu_gnt, ifu_rvalid, lsu_rvalid});
        end
        @(posedge clk); #1;
        m_gnt = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({mem_req, ifu_gnt, ifu_rvalid, lsu_rvalid} !== 4'b1100) begin
            n_fail++;
            $display("FAIL stray_gnt_and_rvalid req/gnt/rvalid=%b need 1100", {mem_req, ifu_gnt, ifu_rvalid, lsu_rvalid});
        end
        @(posedge clk); #1;
        ifu_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h1357_9BDF;
        @(negedge clk);
        n_tests++;
        if ({busy, mem_req, ifu_rvalid} !== 3'b100) begin
            n_fail++;
            $display("FAIL stray_resp_wait busy/req/rvalid=%b need 100", {busy, mem_req, ifu_rvalid});
        end
        @(posedge clk); #1;
        m_rvalid = 1'b1;
        exp_q.push_back('{owner: 2'd0, data: 32'h1357_9BDF});
        @(negedge clk);
        n_tests++;
        if ({ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata} !== {2'b10, 32'h1357_9BDF, 32'h0}) begin
            n_fail++;
            $display("FAIL stray_route rvalid=%b%b rdata=%h/%h need 10 13579bdf/00000000", ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata);
        end
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_back_idle busy=%b need 0", busy);
        end
        wait_obs(rd_idx + exp_q.size(), ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stray_sb_timeout got %0d responses need %0d", obs_cnt - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_cnt && rd_idx < 256) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_owner[rd_idx[7:0]] !== e.owner || obs_data[rd_idx[7:0]] !== e.data) begin
                n_fail++;
                $display("FAIL stray_sb owner=%0d data=%h need owner=%0d data=%h", obs_owner[rd_idx[7:0]], obs_data[rd_idx[7:0]], e.owner, e.data);
            end
            rd_idx++;
        end
        exp_q.delete();
        $display("[TB] stray response done");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        @(posedge clk); #1;
        auto_mem = 1'b0;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0300;
        @(posedge clk); #1;
        m_gnt = 1'b1;
        @(posedge clk); #1;
        m_gnt = 1'b0; ifu_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, mem_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmid_in_resp busy/req=%b need 10", {busy, mem_req});
        end
        #1;
        rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0000;
        #1;
        n_tests++;
        if ({busy, mem_req, mem_addr, ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async busy=%b req=%b addr=%h rvalid=%b%b rdata=%h need all zero",
                     busy, mem_req, mem_addr, ifu_rvalid, lsu_rvalid, ifu_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, ifu_rvalid, lsu_rvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_stray busy/rvalid=%b need 000", {busy, ifu_rvalid, lsu_rvalid});
        end
        @(posedge clk); #1;
        m_rvalid = 1'b0; m_rdata = '0;
        auto_mem = 1'b1; gnt_delay = 0; resp_delay = 0;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0400;
        exp_q.push_back('{owner: 2'd0, data: model(32'h8000_0400)});
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (ifu_gnt) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_regrant ifu_gnt=0 need 1 within 10 cycles"); end
        @(posedge clk); #1;
        ifu_req = 1'b0;
        wait_obs(rd_idx + exp_q.size(), ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_sb_timeout got %0d responses need %0d", obs_cnt - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_cnt && rd_idx < 256) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_owner[rd_idx[7:0]] !== e.owner || obs_data[rd_idx[7:0]] !== e.data) begin
                n_fail++;
                $display("FAIL rstmid_sb owner=%0d data=%h need owner=%0d data=%h", obs_owner[rd_idx[7:0]], obs_data[rd_idx[7:0]], e.owner, e.data);
            end
            rd_idx++;
        end
        exp_q.delete();
        $display("[TB] reset mid-transaction done");
    endtask

    task automatic test_dropped();
        exp_t e;
        bit   ok;
        int   gnt_cnt = 0;
        gnt_delay = 2; resp_delay = 1;
        repeat (2) @(posedge clk);
        #1;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_3000; lsu_wstrb = '0;
        exp_q.push_back('{owner: 2'd1, data: model(32'h8000_3000)});
        @(posedge clk); #1;
        lsu_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({mem_req, lsu_gnt, mem_addr} !== {2'b10, 32'h8000_3000}) begin
            n_fail++;
            $display("FAIL drop_req req=%b gnt=%b addr=%h need 1/0/80003000", mem_req, lsu_gnt, mem_addr);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (lsu_gnt) gnt_cnt++;
        end
        n_tests++;
        if (gnt_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_gnt_count gnts=%0d busy=%b need 1/0", gnt_cnt, busy);
        end
        wait_obs(rd_idx + exp_q.size(), ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL drop_sb_timeout got %0d responses need %0d", obs_cnt - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_cnt && rd_idx < 256) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_owner[rd_idx[7:0]] !== e.owner || obs_data[rd_idx[7:0]] !== e.data) begin
                n_fail++;
                $display("FAIL drop_sb owner=%0d data=%h need owner=%0d data=%h", obs_owner[rd_idx[7:0]], obs_data[rd_idx[7:0]], e.owner, e.data);
            end
            rd_idx++;
        end
        exp_q.delete();
        repeat (5) @(posedge clk);
        n_tests++;
        if (obs_cnt != rd_idx) begin
            n_fail++;
            $display("FAIL extra_responses got %0d unexpected rvalid pulses need 0", obs_cnt - rd_idx);
        end
        $display("[TB] dropped request done");
    endtask

    initial begin
        test_reset();
        test_single_ifu();
        test_store_stall();
        test_tie();
        test_stray();
        test_reset_mid();
        test_dropped();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory port arbiter for the npc core. The instruction fetch path (IFU) and the load/store path (LSU) share a single memory port. The arbiter grants that port round-robin, carries one outstanding transaction at a time, and routes the response back to its owner. It sits between the core's fetch/LSU logic and the memory model, and lets the single-cycle core move to multi-cycle memory accesses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req  in  1  fetch request; held until ifu_gnt
- ifu_addr  in  ADDR_W  fetch address
- ifu_gnt  out  1  fetch request accepted this cycle
- ifu_rvalid  out  1  fetch data valid
- ifu_rdata  out  DATA_W  fetch data
- lsu_req  in  1  load/store request; held until lsu_gnt
- lsu_we  in  1  1 = store
- lsu_addr  in  ADDR_W  access address
- lsu_wdata  in  DATA_W  store data
- lsu_wstrb  in  DATA_W/8  byte enables
- lsu_gnt  out  1  LSU request accepted this cycle
- lsu_rvalid  out  1  load data valid / store acknowledge
- lsu_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  memory response valid; exactly one per granted request, including stores
- mem_rdata  in  DATA_W  response data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, RESP. One-bit `owner` (0 = IFU, 1 = LSU). One-bit `last` holds the most recent winner.
- IDLE behaviour:
  - If any request is present, pick a winner.
  - A sole requester wins.
  - If both request, the winner is the one that is not `last`.
  - Latch the winner's fields into the mem_* registers; IFU latches mem_we=0, mem_wstrb=0, mem_wdata=0.
  - Set owner and last to the winner, then go to REQ.
- REQ behaviour:
  - mem_req=1 with the latched fields stable.
  - ifu_gnt = mem_gnt & REQ & owner==0; lsu_gnt = mem_gnt & REQ & owner==1 (combinational).
  - On mem_gnt, go to RESP.
- RESP behaviour:
  - mem_req=0.
  - On mem_rvalid, route it: the owner's rvalid = mem_rvalid and its rdata = mem_rdata (combinational). The non-owner's rvalid stays 0 and its rdata = 0.
  - Then go to IDLE.
- mem_rvalid outside RESP is a protocol error and is ignored: no rvalid on either side.
- A requester may drop req before its gnt; the latched transaction still completes, and the response is delivered to the owner.
- The requester's fields are sampled only in IDLE. Changes after latch have no effect on the current transaction.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, last=1 (LSU), so the first tie goes to IFU.
  - mem_req=0, all mem_* fields 0.
  - All gnt/rvalid outputs 0, rdata 0, busy=0.
  - Reset during REQ or RESP abandons the transaction. A stray mem_rvalid after reset is ignored per the rule above.
- Request in IDLE at cycle t:
  - mem_req=1 from t+1.
  - The earliest grant is t+1 (mem_gnt=1 at t+1), which is also the requester's gnt.
  - The earliest response is t+2; rvalid appears in the same cycle as mem_rvalid.
  - IDLE again at t+3.
- Minimum occupancy is 3 cycles per transaction, with one IDLE bubble between back-to-back transactions.
- mem_req holds high across any number of mem_gnt=0 cycles. Response latency in RESP is unbounded.
- Simultaneous mem_gnt and mem_rvalid in REQ: the gnt is taken and the rvalid is ignored.

## Test plan
- Single IFU fetch:
  - Stimulus: ifu_req=1, ifu_addr=0x80000000; memory grants immediately and returns 0x00000413 one cycle later.
  - Required: ifu_gnt at t+1, ifu_rvalid with 0x00000413 at t+2, busy high for t+1..t+2.
- LSU store with stalls:
  - Stimulus: lsu_we=1, addr=0x80001000, wdata=0xDEADBEEF, wstrb=0xF; mem_gnt delayed 3 cycles.
  - Required: mem_req held 4 cycles with stable fields, single lsu_gnt pulse, lsu_rvalid on ack, ifu_rvalid stays 0.
- Tie after reset:
  - Stimulus: both requesters continuously requesting.
  - Required: grant order IFU, LSU, IFU, LSU; no requester is granted twice in a row.
- Stray response:
  - Stimulus: mem_rvalid=1 while in IDLE and while in REQ.
  - Required: no rvalid on either side; state unchanged except a REQ→RESP transition when mem_gnt is also high.
- Reset mid-transaction:
  - Stimulus: assert rst low during RESP.
  - Required: outputs go to their reset values immediately; after release, a new IFU request completes normally.
- Dropped request:
  - Stimulus: lsu_req deasserted in REQ before mem_gnt.
  - Required: the transaction still completes and lsu_rvalid is delivered once.
